_rr_mux: RTL
============

// Module: _rr_mux
//
// PURPOSE
//   Parametrised m-input, n-bit arbitrated multiplexer with one registered output stage.
//   Selection is made internally by a round-robin or fixed-priority arbiter,
//     not by an external sel line.
//   Used wherever several producers share one consumer, e.g. register-file write ports
//     or a shared memory request bus.
//   Each input and the output use a valid/ready handshake.
//
// PARAMETERS
//   n      BIT_WIDTH  data width in bits (BIT_WIDTH from constants.vh)
//   m      4          number of input channels, >= 2
//   MODE   0          0 = round-robin; 1 = fixed priority, lowest index wins
//   SW     $clog2(m)  width of source index (localparam, not overridable)
//
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   m      per-channel valid
//   in_data    in   m*n    flattened inputs; channel i = in_data[i*n +: n]
//   in_ready   out  m      per-channel ready; one-hot or zero
//   out_valid  out  1      output register holds a word
//   out_data   out  n      registered selected word
//   out_sel    out  SW     index of the channel that supplied out_data
//   out_ready  in   1      consumer accepts the word this cycle
//
// BEHAVIOUR
//   - Reset (rst=1 at edge): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
//     While rst=1, in_ready is forced to 0.
//     Reset takes priority over any handshake in the same cycle.
//     Any held word is discarded.
//   - load = ~out_valid | out_ready.
//     The register is empty or being drained this cycle, so full throughput is 1 word/cycle.
//   - Grant, combinational:
//     - MODE 0: first i with in_valid[i]=1, searching ptr, ptr+1, ..., m-1, 0, ..., ptr-1.
//     - MODE 1: lowest i with in_valid[i]=1.
//     - No valid input: no grant.
//   - in_ready[i] = load & grant[i]. At most one bit is set.
//   - An input transfer occurs when in_valid[i] & in_ready[i].
//     At the following edge: out_data<=in_data[i], out_sel<=i, out_valid<=1.
//   - Latency from input transfer to out_valid is 1 cycle.
//   - Output transfer occurs when out_valid & out_ready.
//     If there is no simultaneous input transfer, out_valid<=0 at the edge.
//     out_data and out_sel hold their last value.
//   - Simultaneous output and input transfer: the register is overwritten with the new word.
//     out_valid stays 1, with no bubble.
//   - Backpressure: while out_valid=1 and out_ready=0:
//     - out_data and out_sel stay stable.
//     - All in_ready bits are 0.
//     - ptr does not change.
//   - ptr update, MODE 0 only: on an input transfer from channel i, ptr<=(i+1) mod m.
//     Wrap from m-1 goes to 0.
//     ptr only changes on a transfer.
//     In MODE 1, ptr is held at 0 and unused.
//   - Sources must hold in_valid and in_data until the transfer.
//     If a source drops valid before the transfer, the grant re-evaluates that cycle with no error.
//   - m that is not a power of 2: ptr wraps at m, not 2^SW.
//     Indices >= m are never produced.
//
// TESTING
//   1. Reset with all inputs valid:
//      rst=1 for 2 cycles -> out_valid=0, out_data=0, in_ready=0 during reset.
//      First grant after reset goes to channel 0.
//   2. Single channel, MODE 0, m=4: in_valid=4'b0100, data=0xA5, out_ready=1
//      -> in_ready=4'b0100 in the same cycle.
//      Next cycle: out_valid=1, out_data=0xA5, out_sel=2.
//   3. All four valid, out_ready=1, MODE 0 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles.
//      Each channel's data is delivered once per turn.
//   4. Backpressure: hold out_ready=0 for 5 cycles with all valid.
//      -> out_data/out_sel are frozen, in_ready=0, and ptr is unchanged.
//      Release -> the next grant continues from the frozen ptr.
//   5. MODE 1, channels 1 and 3 valid continuously -> out_sel=1 every cycle.
//      Channel 3 is starved and only served after in_valid[1] drops.
//   6. rst asserted mid-stream while out_valid=1 and out_ready=0
//      -> out_valid=0 the next cycle and ptr=0.
//      The pending word is never presented.

Source files
------------

// File: rtl/_rr_mux.sv
// _rr_mux: m-input arbitrated multiplexer with one registered output stage.
// Round-robin (MODE 0) or fixed-priority (MODE 1) selection, valid/ready on every port.
module _rr_mux #(
    parameter int n    = 32,
    parameter int m    = 4,
    parameter int MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [m-1:0]   in_valid,
    input  logic [m*n-1:0] in_data,
    output logic [m-1:0]   in_ready,
    output logic           out_valid,
    output logic [n-1:0]   out_data,
    output logic [$clog2(m)-1:0] out_sel,
    input  logic           out_ready
);

    localparam int SW = $clog2(m);

    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt_idx;
    logic [n-1:0]  gnt_data;
    logic          found;
    logic          load;
    logic          xfer;

    // The register can take a new word when empty or being drained.
    assign load = ~out_valid | out_ready;

    // Search for the first valid channel starting at ptr (MODE 0) or 0 (MODE 1).
    always_comb begin
        int idx;
        logic [SW-1:0] isel;
        idx      = 0;
        isel     = '0;
        found    = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        for (int k = 0; k < m; k++) begin
            idx = (MODE == 0) ? int'(ptr) + k : k;
            if (idx >= m) begin
                idx = idx - m;
            end
            isel = idx[SW-1:0];
            if (!found && in_valid[isel]) begin
                found    = 1'b1;
                gnt_idx  = isel;
                gnt_data = in_data[isel*n +: n];
            end
        end
    end

    assign xfer = found & load & ~rst;

    // One-hot ready towards the granted producer, zero under reset or stall.
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
            if (MODE == 0) begin
                if (gnt_idx == SW'(m - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gnt_idx + 1'b1;
                end
            end else begin
                ptr <= '0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
